// File: rtl/mul_div_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: op codes in funct3
// order, FSM states and the width of the {div_zero, div_ovf} flag pair.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MulOp    = 3'd0,
        MulhOp   = 3'd1,
        MulhsuOp = 3'd2,
        MulhuOp  = 3'd3,
        DivOp    = 3'd4,
        DivuOp   = 3'd5,
        RemOp    = 3'd6,
        RemuOp   = 3'd7
    } MD_Ops;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2,
        StDone = 2'd3
    } MD_State;

    localparam int MD_FLAG_W = 2;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: y = neg ? -x : x, combinational, any width.
module mdu_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = neg_i ? (~x_i + WIDTH'(1)) : x_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiply / restoring divide, DATA_WIDTH iterations, result + done pulse.
// Define MDU_FAST_SPECIAL_EN to finish divide-by-zero and MIN_NEG/-1 in one cycle from IDLE.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  MD_Ops                 op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  div_zero_o,
    output logic                  div_ovf_o
);

    localparam int W         = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    MD_State              state_q, state_d;
    MD_Ops                op_q, op_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0]         bmag_q, bmag_d, a_q, a_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic                 dz_q, dz_d, ovf_q, ovf_d;
    logic [W-1:0]         result_q, result_d;
    logic [MD_FLAG_W-1:0] flags_q, flags_d;

    logic         sign_a, sign_b, b_zero, ovf_in;
    logic [W-1:0] a_mag, b_mag, quo_fix, rem_fix;
    logic [2*W-1:0] prod_fix;
    logic [W:0]   mul_sum, div_shift, div_diff;

    assign sign_a = a_i[W-1] & (op_i inside {MulOp, MulhOp, MulhsuOp, DivOp, RemOp});
    assign sign_b = b_i[W-1] & (op_i inside {MulOp, MulhOp, DivOp, RemOp});
    assign b_zero = (b_i == '0);
    assign ovf_in = (op_i inside {DivOp, RemOp}) && (a_i == MIN_NEG) && (b_i == '1);

    mdu_negate #(.WIDTH(W)) u_neg_a (.x_i(a_i), .neg_i(sign_a), .y_o(a_mag));
    mdu_negate #(.WIDTH(W)) u_neg_b (.x_i(b_i), .neg_i(sign_b), .y_o(b_mag));

    // hi/lo double as product accumulator (multiply) or remainder/quotient (divide).
    assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? bmag_q : '0)};
    assign div_shift = {hi_q, lo_q[W-1]};
    assign div_diff  = div_shift - {1'b0, bmag_q};

    mdu_negate #(.WIDTH(2*W)) u_neg_prod (.x_i({hi_q, lo_q}), .neg_i(sa_q ^ sb_q), .y_o(prod_fix));
    mdu_negate #(.WIDTH(W))   u_neg_quo  (.x_i(lo_q), .neg_i(sa_q ^ sb_q), .y_o(quo_fix));
    mdu_negate #(.WIDTH(W))   u_neg_rem  (.x_i(hi_q), .neg_i(sa_q), .y_o(rem_fix));

    function automatic logic [W-1:0] special_result(input MD_Ops op, input logic [W-1:0] a,
                                                    input logic by_zero);
        if (by_zero) return op[1] ? a : '1;
        return op[1] ? '0 : MIN_NEG;
    endfunction

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        bmag_d   = bmag_q;
        a_d      = a_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    op_d    = op_i;
                    cnt_d   = CNT_WIDTH'(W - 1);
                    hi_d    = '0;
                    lo_d    = a_mag;
                    bmag_d  = b_mag;
                    a_d     = a_i;
                    sa_d    = sign_a;
                    sb_d    = sign_b;
                    dz_d    = op_i[2] & b_zero;
                    ovf_d   = ovf_in;
`ifdef MDU_FAST_SPECIAL_EN
                    if (op_i[2] && (b_zero || ovf_in)) begin
                        state_d  = StDone;
                        result_d = special_result(op_i, a_i, b_zero);
                        flags_d  = {b_zero, ovf_in};
                    end
`endif
                end
            end
            StRun: begin
                if (op_q[2]) begin
                    // MSB of the difference doubles as the borrow: remainder < divisor always.
                    if (!div_diff[W]) begin
                        hi_d = div_diff[W-1:0];
                        lo_d = {lo_q[W-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[W-1:0];
                        lo_d = {lo_q[W-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[W:1];
                    lo_d = {mul_sum[0], lo_q[W-1:1]};
                end
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == '0) state_d = StFin;
            end
            StFin: begin
                state_d = StDone;
                if (!op_q[2]) begin
                    result_d = (op_q == MulOp) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
                    flags_d  = '0;
                end else begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                    if (dz_q || ovf_q) result_d = special_result(op_q, a_q, dz_q);
                    flags_d  = {dz_q, ovf_q};
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            op_q     <= MulOp;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            bmag_q   <= '0;
            a_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            bmag_q   <= bmag_d;
            a_q      <= a_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign ready_o    = (state_q == StIdle);
    assign done_o     = (state_q == StDone);
    assign result_o   = result_q;
    assign div_zero_o = flags_q[1];
    assign div_ovf_o  = flags_q[0];

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model plus literal pins.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;
`ifdef MDU_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = W + 1;
`endif

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    MD_Ops        op_i = MulOp;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         ready_o, done_o, div_zero_o, div_ovf_o;
    logic [W-1:0] result_o;

    mul_div_unit #(.DATA_WIDTH(W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .ready_o(ready_o), .done_o(done_o),
        .result_o(result_o), .div_zero_o(div_zero_o), .div_ovf_o(div_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         dz;
        logic         ovf;
        logic         has_lit;
        logic [W-1:0] lit;
        int           start;
        int           lat;
    } exp_t;

    typedef struct {
        MD_Ops        op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         has_lit;
        logic [W-1:0] lit;
    } vec_t;

    exp_t         q[$];
    logic [W-1:0] held_res = '0;
    logic         held_dz = 1'b0;
    logic         held_ovf = 1'b0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", nm, cyc);
    endtask

    function automatic exp_t model(input MD_Ops op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        p  = '0;
        e.name = "";
        e.has_lit = 1'b0;
        e.lit = '0;
        e.start = 0;
        e.res = '0;
        e.dz  = op[2] && (b == 0);
        e.ovf = (op == DivOp || op == RemOp) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (op)
            MulOp:    begin p = sa * sb; e.res = p[31:0];  end
            MulhOp:   begin p = sa * sb; e.res = p[63:32]; end
            MulhsuOp: begin p = sa * ub; e.res = p[63:32]; end
            MulhuOp:  begin p = {32'h0, a} * {32'h0, b}; e.res = p[63:32]; end
            DivOp:    e.res = e.dz ? '1 : (e.ovf ? a : W'(ia / ib));
            DivuOp:   e.res = e.dz ? '1 : a / b;
            RemOp:    e.res = e.dz ? a : (e.ovf ? '0 : W'(ia % ib));
            default:  e.res = e.dz ? a : a % b;
        endcase
        e.lat = (e.dz || e.ovf) ? SPECIAL_LAT : W + 1;
        return e;
    endfunction

    // Compare process: every non-reset cycle checks handshake, held outputs, and each done pulse.
    always @(negedge clk_i) begin
        exp_t e;
        if (reset_i) begin
            q.delete();
            held_res = '0;
            held_dz  = 1'b0;
            held_ovf = 1'b0;
        end else begin
            chk("ready_o", W'(ready_o), W'(q.size() == 0));
            if (done_o) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done: got done_o=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk({e.name, " result"}, result_o, e.res);
                    chk({e.name, " div_zero"}, W'(div_zero_o), W'(e.dz));
                    chk({e.name, " div_ovf"}, W'(div_ovf_o), W'(e.ovf));
                    chk({e.name, " latency"}, W'(cyc - e.start), W'(e.lat));
                    if (e.has_lit) chk({e.name, " literal"}, result_o, e.lit);
                    held_res = e.res;
                    held_dz  = e.dz;
                    held_ovf = e.ovf;
                end
            end else begin
                chk("held result_o", result_o, held_res);
                chk("held div_zero_o", W'(div_zero_o), W'(held_dz));
                chk("held div_ovf_o", W'(div_ovf_o), W'(held_ovf));
            end
        end
    end

    task automatic start_op(input string nm, input MD_Ops op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic has_lit, input logic [W-1:0] lit);
        exp_t e;
        int   budget = 0;
        while (!ready_o && budget < 200) begin
            @(posedge clk_i);
            #1;
            budget++;
        end
        if (!ready_o) timeout_fail({nm, " ready"});
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
        op_i    = MD_Ops'($urandom_range(0, 7));
        e = model(op, a, b);
        e.name    = nm;
        e.has_lit = has_lit;
        e.lit     = lit;
        e.start   = cyc;
        q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int budget = 0;
        while (!(q.size() == 0 && ready_o) && budget < 100) begin
            @(posedge clk_i);
            #1;
            budget++;
        end
        if (!(q.size() == 0 && ready_o)) timeout_fail({nm, " completion"});
    endtask

    vec_t vecs[] = '{
        '{MulOp,    32'd7,         32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB},
        '{MulhOp,   32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000},
        '{MulhsuOp, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF},
        '{MulhuOp,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE},
        '{DivOp,    32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD},
        '{RemOp,    32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF},
        '{DivuOp,   32'd100,       32'd7,         1'b1, 32'd14},
        '{RemuOp,   32'd100,       32'd7,         1'b1, 32'd2},
        '{DivOp,    32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF},
        '{RemOp,    32'd5,         32'd0,         1'b1, 32'd5},
        '{DivOp,    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000},
        '{RemOp,    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0},
        '{MulOp,    32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'd0},
        '{DivOp,    32'hFFFF_FFF9, 32'd0,         1'b1, 32'hFFFF_FFFF},
        '{RemOp,    32'hFFFF_FFF9, 32'd0,         1'b1, 32'hFFFF_FFF9},
        '{RemuOp,   32'h8000_0003, 32'd0,         1'b1, 32'h8000_0003},
        '{DivuOp,   32'hFFFF_FFFF, 32'd0,         1'b1, 32'hFFFF_FFFF},
        '{MulhOp,   32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'd0},
        '{MulhuOp,  32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'd0},
        '{DivOp,    32'd5,         32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFB},
        '{RemOp,    32'h8000_0000, 32'd7,         1'b0, 32'd0},
        '{DivuOp,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0},
        '{RemuOp,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000}
    };

    initial begin
        // Reset with a start request held high: it must not launch anything.
        start_i = 1'b1;
        op_i    = DivOp;
        a_i     = 32'd9;
        b_i     = 32'd3;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("reset ready_o", W'(ready_o), W'(1));
        chk("reset done_o", W'(done_o), W'(0));
        chk("reset result_o", result_o, 32'd0);
        chk("reset div_zero_o", W'(div_zero_o), W'(0));
        chk("reset div_ovf_o", W'(div_ovf_o), W'(0));
        @(posedge clk_i);
        #1;

        foreach (vecs[i]) begin
            start_op($sformatf("v%0d_%s", i, vecs[i].op.name()), vecs[i].op, vecs[i].a,
                     vecs[i].b, vecs[i].has_lit, vecs[i].lit);
            wait_idle($sformatf("v%0d", i));
        end

        // A start pulse during RUN must be ignored.
        start_op("mul_ignored_start", MulOp, 32'd1234, 32'd5678, 1'b1, 32'd7006652);
        repeat (5) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        op_i    = DivuOp;
        a_i     = 32'd77;
        b_i     = 32'd3;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_idle("ignored_start");

        // Reset ten cycles into a divide: abort, no done pulse, outputs cleared.
        start_op("div_abort", DivOp, 32'd1000, 32'd7, 1'b0, 32'd0);
        repeat (9) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("abort ready_o", W'(ready_o), W'(1));
        chk("abort result_o", result_o, 32'd0);
        repeat (45) @(posedge clk_i);
        #1;

        start_op("mul_after_abort", MulOp, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd1);
        wait_idle("mul_after_abort");
        repeat (2) @(posedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
